// File: rtl/adder_30_pkg.sv
// adder_30_pkg -- constants and types shared by the adder_30 slice.
//   WIDTH         operand/result width (fixed at 30)
//   PREFIX_LEVELS Kogge-Stone prefix depth, ceil(log2(WIDTH))
//   word_t        one operand/result word
package adder_30_pkg;

    localparam int unsigned WIDTH         = 30;
    localparam int unsigned PREFIX_LEVELS = 5;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/adder_30_pg_cell.sv
// adder_30_pg_cell -- Kogge-Stone prefix operator.
// Merges a higher group (gh, ph) with the adjacent lower group (gl, pl)
// into one wider group (g, p).
//   gh, ph  generate/propagate of the higher-order group
//   gl, pl  generate/propagate of the lower-order group
//   g, p    generate/propagate of the merged group
module adder_30_pg_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    always_comb begin
        g = gh | (ph & gl);
        p = ph & pl;
    end

endmodule

// File: rtl/adder_30.sv
// adder_30 -- registered 30-bit adder, C = (A + B) mod 2^WIDTH.
// Carries come from a Kogge-Stone parallel-prefix network; there is no
// carry-out, no overflow flag and no saturation, so signed and unsigned
// operands give the same bits.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears all registers
//   A, B   operands
//   C      registered sum
// Build option ADDER_30_INREG_EN: registers A and B ahead of the prefix
// network (latency 2 instead of 1).
module adder_30 #(
    parameter int unsigned WIDTH = adder_30_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C
);

    import adder_30_pkg::PREFIX_LEVELS;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

`ifdef ADDER_30_INREG_EN
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] b_q;

    always_comb begin
        a_d = A;
        b_d = B;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    always_comb begin
        op_a = a_q;
        op_b = b_q;
    end
`else
    always_comb begin
        op_a = A;
        op_b = B;
    end
`endif

    // Level 0 holds bitwise generate/propagate; level l merges groups that
    // are 2^(l-1) bits apart. Bits below the span already reach bit 0 and
    // pass through unchanged. After the last level lvl[..].g[i] is the
    // carry out of bit i.
    for (genvar l = 0; l <= PREFIX_LEVELS; l++) begin : lvl
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;

        if (l == 0) begin : g_init
            always_comb begin
                g = op_a & op_b;
                p = op_a ^ op_b;
            end
        end else begin : g_merge
            localparam int unsigned SPAN = 1 << (l - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : bit_g
                if (i >= SPAN) begin : g_cell
                    adder_30_pg_cell u_cell (
                        .gh (lvl[l-1].g[i]),
                        .ph (lvl[l-1].p[i]),
                        .gl (lvl[l-1].g[i-SPAN]),
                        .pl (lvl[l-1].p[i-SPAN]),
                        .g  (g[i]),
                        .p  (p[i])
                    );
                end else begin : g_pass
                    assign g[i] = lvl[l-1].g[i];
                    assign p[i] = lvl[l-1].p[i];
                end
            end
        end
    end

    // The top carry and the final group propagates have no consumer
    // because the sum wraps.
    logic             carry_out_unused;
    logic [WIDTH-1:0] prop_unused;

    always_comb begin
        carry_out_unused = lvl[PREFIX_LEVELS].g[WIDTH-1];
        prop_unused      = lvl[PREFIX_LEVELS].p;
    end

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] c_d;
    logic [WIDTH-1:0] c_q;

    always_comb begin
        carry = {lvl[PREFIX_LEVELS].g[WIDTH-2:0], 1'b0};
        c_d   = lvl[0].p ^ carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    always_comb begin
        C = c_q;
    end

endmodule

// File: tb/tb_adder_30.sv
// tb_adder_30 -- self-checking bench for adder_30.
// A reference model (modular sum delayed by the configured latency, zeroed
// by reset) is checked against C on every falling clock edge; directed
// vectors with hand-computed sums pin the model and the DUT.
module tb_adder_30;

    import adder_30_pkg::*;

`ifdef ADDER_30_INREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    localparam int unsigned NV = 12;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b1;
    word_t A     = '0;
    word_t B     = '0;
    word_t C;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    bit          chk_en    = 1'b0;

    word_t exp_c = '0;
    word_t pipe[$];

    word_t va [NV] = '{30'd31, 30'd0, 30'd16, 30'd15, 30'h3FFFFFF8, 30'h3FFFFFF0,
                       30'd14, 30'h3FFFFFFF, 30'h2AAAAAAA, 30'h3FFFFFFF, 30'h12345678,
                       30'h20000000};
    word_t vb [NV] = '{30'h3FFFFFE1, 30'd0, 30'd8, 30'd16, 30'h3FFFFFF7, 30'h3FFFFFF0,
                       30'h3FFFFFF0, 30'd1, 30'h15555555, 30'h3FFFFFFF, 30'h0ABCDEF0,
                       30'h20000000};
    word_t vs [NV] = '{30'h00000000, 30'd0, 30'd24, 30'd31, 30'h3FFFFFEF, 30'h3FFFFFE0,
                       30'h3FFFFFFE, 30'h00000000, 30'h3FFFFFFF, 30'h3FFFFFFE, 30'h1CF13568,
                       30'h00000000};

    adder_30 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C     (C)
    );

    always #5 clk = ~clk;

    function automatic word_t model_sum(input word_t a, input word_t b);
        longint unsigned s;
        s = 64'(a) + 64'(b);
        return word_t'(s % (64'd1 << WIDTH));
    endfunction

    task automatic check(input string name, input word_t act, input word_t exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: C=0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: sums emerge LAT edges after sampling; reset empties the pipe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe.delete();
            for (int unsigned i = 1; i < LAT; i++) pipe.push_back('0);
            exp_c <= '0;
        end else begin
            pipe.push_back(model_sum(A, B));
            exp_c <= pipe.pop_front();
        end
    end

    always @(negedge clk) begin
        if (chk_en) check("model_c", C, exp_c);
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_c", C, '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed vectors, each held until its sum has emerged.
        for (int k = 0; k < int'(NV); k++) begin
            @(posedge clk);
            #2;
            A = va[k];
            B = vb[k];
            repeat (LAT) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", k), C, vs[k]);
        end

        // Input changes between edges must not reach C.
        A = 30'h1234567;
        B = 30'h0000FFF;
        #1 check("hold_between_edges", C, vs[NV-1]);
        A = va[NV-1];
        B = vb[NV-1];

        // Latency: 16 + 8 applied just after an edge.
        @(posedge clk);
        #2;
        A = 30'd16;
        B = 30'd8;
        @(negedge clk);
        check("lat_before_edge", C, vs[NV-1]);
        @(negedge clk);
        check("lat_edge1", C, (LAT == 1) ? 30'd24 : vs[NV-1]);
        @(negedge clk);
        check("lat_edge2", C, 30'd24);

        // Back-to-back stream with an asynchronous reset pulse mid-stream.
        for (int k = 0; k < int'(NV); k++) begin
            @(posedge clk);
            #2;
            A = va[k];
            B = vb[k];
            if (k == 5) begin
                #1 rst_n = 1'b0;
                #1 check("async_reset_c", C, '0);
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
            end
        end

        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);
        check("stream_tail", C, vs[NV-1]);
        #1 chk_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
